// File: rtl/conv_8a32.sv
// conv_8a32: receive-side byte-to-word assembler.
// Collects 8-bit symbols (plus K flags) into 32/16/8-bit words selected by
// PCLK, with word boundaries aligned to the COM K-code, MSB byte first.
// Optional build macro CONV_SKP_REMOVE_EN: drop SKP K-codes while locked.
module conv_8a32 #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter logic [7:0] SKP_SYMBOL = 8'h1C
) (
    input  logic        CLK,
    input  logic        RESET_CONV,
    input  logic        ENB,
    input  logic [1:0]  PCLK,
    input  logic [7:0]  in,
    input  logic        in_valid,
    input  logic        K,
    output logic [31:0] out,
    output logic [3:0]  K_out,
    output logic        out_valid,
    output logic        locked,
    output logic        align_err
);

`ifdef CONV_SKP_REMOVE_EN
    localparam bit SKP_REMOVE = 1'b1;
`else
    localparam bit SKP_REMOVE = 1'b0;
`endif

    typedef enum logic {ST_ALIGN = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    // r_len encodes the latched word length: 0 = 4 bytes, 1 = 2 bytes, 2 = 1 byte
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_len, w_len_nxt;
    logic [31:0] r_buf, w_buf_nxt;
    logic [3:0]  r_kbuf, w_kbuf_nxt;
    logic [31:0] r_out, w_out_nxt;
    logic [3:0]  r_kout, w_kout_nxt;
    logic        r_ov, w_ov_nxt;
    logic        r_err, w_err_nxt;

    logic        w_acc, w_com, w_skp, w_drop;
    logic        w_store, w_first, w_last;
    logic [1:0]  w_len_sel, w_len_eff, w_idx, w_lane;
    logic [31:0] w_word;
    logic [3:0]  w_kword;

    assign w_acc     = ENB & in_valid;
    assign w_com     = K && (in == COM_SYMBOL);
    assign w_skp     = K && (in == SKP_SYMBOL);
    assign w_drop    = w_skp & SKP_REMOVE;
    assign w_len_sel = (PCLK == 2'b11) ? 2'b10 : PCLK;

    // Next-state / datapath: decide whether to store the byte, where it lands, and word completion
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_buf_nxt   = r_buf;
        w_kbuf_nxt  = r_kbuf;
        w_out_nxt   = r_out;
        w_kout_nxt  = r_kout;
        w_ov_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_store     = 1'b0;
        w_first     = 1'b0;
        w_lane      = 2'd0;
        w_last      = 1'b1;

        if (w_acc) begin
            if (r_state == ST_ALIGN) begin
                if (w_com) begin
                    w_state_nxt = ST_LOCKED;
                    w_store     = 1'b1;
                    w_first     = 1'b1;
                end
            end else if (!w_drop) begin
                w_store = 1'b1;
                if (r_cnt == 2'd0) begin
                    w_first = 1'b1;
                end else if (w_com) begin
                    // COM in mid-word: drop the partial word and restart on this COM
                    w_first   = 1'b1;
                    w_err_nxt = 1'b1;
                end
            end
        end

        // Length is sampled from PCLK only on byte 0; later bytes use the latched value
        w_len_eff = w_first ? w_len_sel : r_len;
        w_idx     = w_first ? 2'd0 : r_cnt;

        case (w_len_eff)
            2'd0: begin
                w_lane = 2'd3 - w_idx;
                w_last = (w_idx == 2'd3);
            end
            2'd1: begin
                w_lane = 2'd1 - w_idx;
                w_last = (w_idx == 2'd1);
            end
            default: begin
                w_lane = 2'd0;
                w_last = 1'b1;
            end
        endcase

        // A new word starts from zero so unused upper lanes read as 0
        w_word  = w_first ? 32'd0 : r_buf;
        w_kword = w_first ? 4'd0  : r_kbuf;
        for (int i = 0; i < 4; i++) begin
            if (w_lane == i[1:0]) begin
                w_word[i*8 +: 8] = in;
                w_kword[i]       = K;
            end
        end

        if (w_store) begin
            w_len_nxt  = w_len_eff;
            w_buf_nxt  = w_word;
            w_kbuf_nxt = w_kword;
            if (w_last) begin
                w_out_nxt  = w_word;
                w_kout_nxt = w_kword;
                w_ov_nxt   = 1'b1;
                w_cnt_nxt  = 2'd0;
            end else begin
                w_cnt_nxt  = w_idx + 2'd1;
            end
        end
    end

    // State and output registers; reset discards any partial word
    always_ff @(posedge CLK or negedge RESET_CONV) begin
        if (!RESET_CONV) begin
            r_state <= ST_ALIGN;
            r_cnt   <= 2'd0;
            r_len   <= 2'd0;
            r_buf   <= 32'd0;
            r_kbuf  <= 4'd0;
            r_out   <= 32'd0;
            r_kout  <= 4'd0;
            r_ov    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_buf   <= w_buf_nxt;
            r_kbuf  <= w_kbuf_nxt;
            r_out   <= w_out_nxt;
            r_kout  <= w_kout_nxt;
            r_ov    <= w_ov_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign out       = r_out;
    assign K_out     = r_kout;
    assign out_valid = r_ov;
    assign align_err = r_err;
    assign locked    = (r_state == ST_LOCKED);

endmodule

// File: doc/conv_8a32.md
Name: conv_8a32

Overview:
- Receive-side byte-to-word assembler. Counterpart of the transmit 32-to-8 converter.
- Sits after the serial-to-parallel block. It takes one 8-bit symbol per accepted cycle plus its K (control) flag.
- Rebuilds 32-, 16- or 8-bit words according to PCLK.
- Aligns word boundaries to the COM symbol, so byte lanes match the transmitter's ordering (MSB byte first).

Parameters:
- COM_SYMBOL, 8'hBC, K-code that marks byte 0 of a word (K28.5).
- SKP_SYMBOL, 8'h1C, K-code removed by the optional feature (K28.0).

Ports:
- CLK  input  1  single clock; all logic is rising-edge.
- RESET_CONV  input  1  asynchronous reset, active-low.
- ENB  input  1  block enable; when low, state and outputs hold and inputs are ignored.
- PCLK  input  2  width select: 00=32 bit, 01=16 bit, 10=8 bit, 11=treated as 8 bit.
- in  input  8  received symbol.
- in_valid  input  1  in/K are valid this cycle.
- K  input  1  in is a control (K) symbol.
- out  output  32  assembled word; 16-bit words in out[15:0], 8-bit words in out[7:0], unused bits 0.
- K_out  output  4  per-byte K flags, same lane mapping as out.
- out_valid  output  1  one-cycle pulse: out/K_out hold a new word.
- locked  output  1  alignment achieved.
- align_err  output  1  one-cycle pulse on misaligned COM.

Behaviour:
- Reset (RESET_CONV=0, async):
  - out=0, K_out=0, out_valid=0, locked=0, align_err=0.
  - Byte counter=0, state=ALIGN.
  - Takes effect immediately, mid-word included; the partial word is discarded.
- Accept condition: ENB=1 and in_valid=1 on a rising edge. All other cycles make no state change and leave out_valid=0.
- Word length N is 4, 2 or 1, latched from PCLK when byte 0 of a word is accepted. A PCLK change mid-word takes effect at the next word.
- Lane order: first byte of a word goes to the most significant used lane.
  - 32-bit: out[31:24], out[23:16], out[15:8], out[7:0].
  - 16-bit: out[15:8], out[7:0].
- State ALIGN:
  - Accepted bytes are discarded until K=1 and in==COM_SYMBOL.
  - That COM is stored as byte 0; state goes to LOCKED, locked=1 on the same edge, counter=1.
  - If N=1, the COM word completes immediately.
- State LOCKED:
  - Each accepted byte is stored at lane[counter] and the counter increments.
  - When counter reaches N, the byte is written and out_valid=1 next cycle with the complete word. The counter wraps to 0.
  - out/K_out stay stable until the next completed word.
  - Latency: out_valid rises one clock after the edge that accepted the last byte.
- Misaligned COM (LOCKED, counter≠0, COM accepted):
  - align_err pulses one cycle.
  - Partial word discarded, no out_valid.
  - The COM becomes byte 0 of a new word (counter=1).
  - locked stays 1.
- COM at counter=0 in LOCKED: normal byte 0.
- Bytes with K=1 other than COM are stored as data, with the K_out bit set.
- Back-to-back accepts: one word per N accepted bytes, no bubble required. out_valid may assert on consecutive cycles when N=1.
- ENB low mid-word: the partial word is retained and resumes when ENB returns.

Optional Feature:
- Macro: CONV_SKP_REMOVE_EN.
- Defined: an accepted byte with K=1 and in==SKP_SYMBOL, in LOCKED state, is dropped. It is not stored, not counted and does not affect the counter, so words contain no SKPs.
- Undefined: SKP is stored as an ordinary K byte.
- In ALIGN state SKP is discarded either way.

Test Plan:
- Reset then PCLK=00, stream K/BC, 0F, 00, 55 with in_valid=1 every cycle -> locked=1 after first edge; one out_valid pulse, out=32'hBC0F0055, K_out=4'b1000.
- Bytes 12, 34 (K=0) before COM, then BC(K), AA, 0F, FF -> first two discarded; out=32'hBCAA0FFF.
- PCLK=01, locked, stream BC(K), 55, A0, 0F -> two pulses: out=32'h0000BC55, then 32'h0000A00F.
- PCLK=00, locked, send BC(K), 11, then BC(K), 22, 33, 44 -> align_err pulse on the second COM; no word for 11; next out=32'hBC223344.
- With CONV_SKP_REMOVE_EN defined, PCLK=00: BC(K), 1C(K), 01, 02, 03 -> out=32'hBC010203. Undefined -> out=32'hBC1C0102, K_out=4'b1100.
- Assert RESET_CONV low mid-word (after 2 bytes) -> out=0, locked=0 immediately. After release, the bytes before the next COM are ignored.
